// File: rtl/axi_ram_pkg.sv
// Shared types for the AXI4 burst RAM: burst encodings, response codes, FSM states.
// Latency: none (declarations only).
// Backpressure: not applicable.
package axi_ram_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wstate_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_t;

  // AXI only allows wrapping bursts of 2, 4, 8 or 16 beats.
  function automatic logic is_legal_wrap_len(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Next beat address and legality/range flags for one AXI burst beat.
// Latency: purely combinational.
// Backpressure: none; the owning channel decides when to consume next_addr.
module axi_burst_addr
  import axi_ram_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int MEM_WORDS = 1024
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        len,
  input  logic [2:0]        size,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr,
  output logic              burst_err,
  output logic              range_err
);

  localparam int OFFS = $clog2(DATA_W/8);

  logic [ADDR_W-1:0] bytes;
  logic [ADDR_W-1:0] mask;
  logic [ADDR_W-1:0] step;
  logic [63:0]       widx;

  // Wrap keeps the low bits inside the aligned container and holds the base bits.
  always_comb begin
    bytes     = ADDR_W'(1) << size;
    mask      = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
    step      = addr + bytes;
    next_addr = addr;
    case (burst)
      BURST_INCR: next_addr = step;
      BURST_WRAP: next_addr = (addr & ~mask) | (step & mask);
      default:    next_addr = addr;
    endcase
    burst_err = (int'(size) > OFFS) || (burst == 2'b11) ||
                ((burst == BURST_WRAP) && !is_legal_wrap_len(len));
    widx      = 64'(addr) >> OFFS;
    range_err = widx >= 64'(MEM_WORDS);
  end

endmodule

// File: rtl/axi_ram_burst.sv
// AXI4 slave RAM with FIXED/INCR/WRAP bursts, byte strobes and SLVERR on bad accesses.
// Latency: B one cycle after the last W beat; first R beat one cycle after AR (registered read).
// Backpressure: one burst per channel in flight; ready drops outside IDLE, R/B outputs hold until accepted.
module axi_ram_burst
  import axi_ram_pkg::*;
#(
  parameter int ID_W      = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int MEM_WORDS = 1024
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                awvalid,
  output logic                awready,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [7:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                wvalid,
  output logic                wready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  output logic                bvalid,
  input  logic                bready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  input  logic                arvalid,
  output logic                arready,
  input  logic [ID_W-1:0]     arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [7:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  output logic                rvalid,
  input  logic                rready,
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast
);

  localparam int STRB_W = DATA_W/8;
  localparam int OFFS   = $clog2(STRB_W);
  localparam int MW     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  logic [DATA_W-1:0] mem [MEM_WORDS];

  // ---------------- write channel ----------------
  wstate_t           w_state, w_state_nx;
  logic [ID_W-1:0]   w_id;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_len;
  logic [2:0]        w_size;
  logic [1:0]        w_burst;
  logic [7:0]        w_cnt;
  logic              w_err;
  logic [ADDR_W-1:0] wa_next;
  logic              wa_burst_err, wa_range_err;
  logic              aw_hs, w_hs, w_last_beat, w_beat_err, w_we;
  logic [MW-1:0]     w_idx;

  axi_burst_addr #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_WORDS(MEM_WORDS)) u_waddr (
    .addr      (w_addr),
    .len       (w_len),
    .size      (w_size),
    .burst     (w_burst),
    .next_addr (wa_next),
    .burst_err (wa_burst_err),
    .range_err (wa_range_err)
  );

  assign aw_hs       = awvalid && awready;
  assign w_hs        = wvalid && wready;
  assign w_last_beat = (w_cnt == w_len);
  // The beat counter decides the end of the burst; a wrong wlast only taints the response.
  assign w_beat_err  = wa_burst_err || wa_range_err || (wlast != w_last_beat);
  assign w_we        = w_hs && !wa_burst_err && !wa_range_err;
  assign w_idx       = w_addr[OFFS +: MW];

  // Write FSM state register.
  always_ff @(posedge aclk) begin
    if (areset) w_state <= W_IDLE;
    else        w_state <= w_state_nx;
  end

  // Write FSM next state and handshake outputs; reset forces all of them low.
  always_comb begin
    w_state_nx = w_state;
    awready    = 1'b0;
    wready     = 1'b0;
    bvalid     = 1'b0;
    case (w_state)
      W_IDLE: begin
        awready = 1'b1;
        if (awvalid) w_state_nx = W_DATA;
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid && w_last_beat) w_state_nx = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) w_state_nx = W_IDLE;
      end
      default: w_state_nx = W_IDLE;
    endcase
    if (areset) begin
      awready = 1'b0;
      wready  = 1'b0;
      bvalid  = 1'b0;
    end
  end

  // Write burst context, beat counter, sticky error and the B response registers.
  always_ff @(posedge aclk) begin
    if (areset) begin
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_cnt   <= '0;
      w_err   <= 1'b0;
      bid     <= '0;
      bresp   <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        w_id    <= awid;
        w_addr  <= awaddr;
        w_len   <= awlen;
        w_size  <= awsize;
        w_burst <= awburst;
        w_cnt   <= '0;
        w_err   <= 1'b0;
      end
      if (w_hs) begin
        w_addr <= wa_next;
        w_cnt  <= w_cnt + 8'd1;
        w_err  <= w_err || w_beat_err;
        if (w_last_beat) begin
          bid   <= w_id;
          bresp <= (w_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
        end
      end
    end
  end

  // Byte-enable write port; contents survive reset.
  always_ff @(posedge aclk) begin
    if (w_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem[w_idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  rstate_t           r_state, r_state_nx;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_len;
  logic [2:0]        r_size;
  logic [1:0]        r_burst;
  logic [7:0]        r_cnt;
  logic [ADDR_W-1:0] ra_addr, ra_next;
  logic [7:0]        ra_len;
  logic [2:0]        ra_size;
  logic [1:0]        ra_burst;
  logic              ra_burst_err, ra_range_err;
  logic              ar_hs, r_hs, r_load;
  logic [MW-1:0]     ra_idx;

  // In IDLE the first beat is looked up straight from the AR channel so data is ready next cycle.
  assign ra_addr  = (r_state == R_IDLE) ? araddr  : r_addr;
  assign ra_len   = (r_state == R_IDLE) ? arlen   : r_len;
  assign ra_size  = (r_state == R_IDLE) ? arsize  : r_size;
  assign ra_burst = (r_state == R_IDLE) ? arburst : r_burst;
  assign ra_idx   = ra_addr[OFFS +: MW];

  axi_burst_addr #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_WORDS(MEM_WORDS)) u_raddr (
    .addr      (ra_addr),
    .len       (ra_len),
    .size      (ra_size),
    .burst     (ra_burst),
    .next_addr (ra_next),
    .burst_err (ra_burst_err),
    .range_err (ra_range_err)
  );

  assign ar_hs  = arvalid && arready;
  assign r_hs   = rvalid && rready;
  assign r_load = ar_hs || (r_hs && !rlast);

  // Read FSM state register.
  always_ff @(posedge aclk) begin
    if (areset) r_state <= R_IDLE;
    else        r_state <= r_state_nx;
  end

  // Read FSM next state and handshake outputs; rvalid simply mirrors R_DATA.
  always_comb begin
    r_state_nx = r_state;
    arready    = 1'b0;
    rvalid     = 1'b0;
    case (r_state)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) r_state_nx = R_DATA;
      end
      R_DATA: begin
        rvalid = 1'b1;
        if (rready && rlast) r_state_nx = R_IDLE;
      end
    endcase
    if (areset) begin
      arready = 1'b0;
      rvalid  = 1'b0;
    end
  end

  // Read context and registered beat; the RAM read here sees pre-write data in a same-cycle collision.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
      rid     <= '0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
      rlast   <= 1'b0;
    end else begin
      if (ar_hs) begin
        r_len   <= arlen;
        r_size  <= arsize;
        r_burst <= arburst;
        r_cnt   <= '0;
        rid     <= arid;
      end else if (r_hs && !rlast) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (r_load) begin
        r_addr <= ra_next;
        rdata  <= (ra_burst_err || ra_range_err) ? '0 : mem[ra_idx];
        rresp  <= (ra_burst_err || ra_range_err) ? RESP_SLVERR : RESP_OKAY;
        rlast  <= ar_hs ? (arlen == 8'd0) : ((r_cnt + 8'd1) == r_len);
      end
    end
  end

endmodule

// File: tb/tb_axi_ram_burst.sv
// Randomized and directed bench for axi_ram_burst against a byte-array memory model.
// Latency: checks B one cycle after last W and first R one cycle after AR.
// Backpressure: stalls bready and rready to check output stability.
module tb_axi_ram_burst;

  localparam int MEM_WORDS = 1024;

  logic        aclk, areset;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [3:0]  awid, bid, arid, rid;
  logic [15:0] awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0]  mem_m [MEM_WORDS*4];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];

  axi_ram_burst #(.ID_W(4), .ADDR_W(16), .DATA_W(32), .MEM_WORDS(MEM_WORDS)) dut (
    .aclk(aclk), .areset(areset),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks so far", n_chk);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Beat address from the burst rules, computed with plain integer arithmetic.
  function automatic logic [15:0] beat_addr(input logic [15:0] start, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst, input int i);
    int bytes, cont, lower, a;
    bytes = 1 << size;
    cont  = (int'(len) + 1) * bytes;
    a     = int'(start);
    if (burst == 2'd1) a = int'(start) + i * bytes;
    else if (burst == 2'd2) begin
      lower = (int'(start) / cont) * cont;
      a = lower + ((int'(start) - lower) + i * bytes) % cont;
    end
    return 16'(a);
  endfunction

  function automatic bit burst_ok(input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    if (size > 3'd2 || burst == 2'd3) return 1'b0;
    if (burst == 2'd2 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit in_range(input logic [15:0] a);
    return (int'(a) >> 2) < MEM_WORDS;
  endfunction

  function automatic logic [31:0] model_word(input logic [15:0] a);
    int w;
    w = int'(a) >> 2;
    return {mem_m[w*4+3], mem_m[w*4+2], mem_m[w*4+1], mem_m[w*4]};
  endfunction

  task automatic do_write(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int bdelay, input bit bad_last);
    bit ok, err;
    logic [15:0] a;
    int w;
    ok  = burst_ok(len, size, burst);
    err = !ok;
    awvalid = 1'b1; awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
    for (int t = 0; t < 20 && !awready; t++) tick();
    check_eq("aw_ready", awready, 1);
    tick();
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i];
      wlast  = (i == int'(len)) ^ (bad_last && i == 0);
      for (int t = 0; t < 20 && !wready; t++) tick();
      check_eq("w_ready", wready, 1);
      tick();
      a = beat_addr(addr, len, size, burst, i);
      if (ok && in_range(a)) begin
        w = int'(a) >> 2;
        for (int b = 0; b < 4; b++) if (ws[i][b]) mem_m[w*4+b] = wd[i][b*8 +: 8];
      end else err = 1'b1;
      if (bad_last && i == 0) err = 1'b1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    check_eq("b_valid", bvalid, 1);
    for (int k = 0; k < bdelay; k++) begin
      tick();
      check_eq("b_hold", bvalid, 1);
      check_eq("aw_blocked", awready, 0);
    end
    check_eq("bid", bid, id);
    check_eq("bresp", bresp, err ? 2'b10 : 2'b00);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check_eq("b_done", bvalid, 0);
  endtask

  task automatic do_read(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input int stall_beat);
    bit ok, okb;
    logic [15:0] a;
    logic [31:0] exp;
    ok = burst_ok(len, size, burst);
    arvalid = 1'b1; arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
    for (int t = 0; t < 20 && !arready; t++) tick();
    check_eq("ar_ready", arready, 1);
    tick();
    arvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      a   = beat_addr(addr, len, size, burst, i);
      okb = ok && in_range(a);
      exp = okb ? model_word(a) : 32'h0;
      check_eq("r_valid", rvalid, 1);
      if (i == stall_beat) begin
        for (int k = 0; k < 3; k++) begin
          tick();
          check_eq("r_hold_vld", rvalid, 1);
          check_eq("r_hold_dat", rdata, exp);
        end
      end
      check_eq("rdata", rdata, exp);
      check_eq("rresp", rresp, okb ? 2'b00 : 2'b10);
      check_eq("rlast", rlast, i == int'(len));
      check_eq("rid", rid, id);
      rready = 1'b1;
      tick();
      rready = 1'b0;
    end
    check_eq("r_done", rvalid, 0);
  endtask

  initial begin
    logic [31:0] old_w;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          r;

    areset = 1'b1;
    awvalid = 0; awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
    arvalid = 0; arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0; rready = 0;
    tick(); tick();
    check_eq("rst_awready", awready, 0);
    check_eq("rst_arready", arready, 0);
    check_eq("rst_wready", wready, 0);
    check_eq("rst_bvalid", bvalid, 0);
    check_eq("rst_rvalid", rvalid, 0);
    check_eq("rst_ids", {bid, rid}, 0);
    check_eq("rst_rdata", rdata, 0);
    check_eq("rst_resps", {bresp, rresp}, 0);
    areset = 1'b0;
    tick();
    check_eq("idle_awready", awready, 1);
    check_eq("idle_arready", arready, 1);

    // Fill the whole RAM so every later read has a known model value.
    for (int k = 0; k < MEM_WORDS / 16; k++) begin
      for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      do_write(4'(k), 16'(k * 64), 8'd15, 3'd2, 2'd1, 0, 1'b0);
    end

    // INCR write then read back.
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
    do_write(4'd1, 16'h0010, 8'd3, 3'd2, 2'd1, 0, 1'b0);
    do_read(4'd2, 16'h0010, 8'd3, 3'd2, 2'd1, -1);

    // WRAP read starting mid-container.
    for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    do_write(4'd3, 16'h0030, 8'd3, 3'd2, 2'd1, 0, 1'b0);
    do_read(4'd5, 16'h0038, 8'd3, 3'd2, 2'd2, -1);

    // FIXED burst merging byte strobes into one cleared word.
    wd[0] = 32'h0; ws[0] = 4'hF;
    do_write(4'd4, 16'h0020, 8'd0, 3'd2, 2'd1, 0, 1'b0);
    wd[0] = 32'hAA; wd[1] = 32'hBB00; wd[2] = 32'hCC0000;
    ws[0] = 4'h1;   ws[1] = 4'h2;     ws[2] = 4'h4;
    do_write(4'd4, 16'h0020, 8'd2, 3'd2, 2'd0, 0, 1'b0);
    do_read(4'd4, 16'h0020, 8'd0, 3'd2, 2'd1, -1);
    check_eq("fixed_merge", model_word(16'h0020), 32'h00CCBBAA);

    // Last word plus one beat past the end; then an oversize beat.
    wd[0] = 32'h1234_5678; wd[1] = 32'h9ABC_DEF0; ws[0] = 4'hF; ws[1] = 4'hF;
    do_write(4'd6, 16'((MEM_WORDS - 1) * 4), 8'd1, 3'd2, 2'd1, 0, 1'b0);
    do_read(4'd6, 16'((MEM_WORDS - 1) * 4), 8'd1, 3'd2, 2'd1, -1);
    wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
    do_write(4'd7, 16'h0040, 8'd0, 3'd3, 2'd1, 0, 1'b0);
    do_read(4'd7, 16'h0040, 8'd0, 3'd2, 2'd1, -1);

    // Back-pressure on B and on R beat 2.
    for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    do_write(4'd8, 16'h0100, 8'd3, 3'd2, 2'd1, 5, 1'b0);
    do_read(4'd9, 16'h0100, 8'd3, 3'd2, 2'd1, 1);

    // Same-cycle write and read of one word returns the old contents.
    old_w = model_word(16'h0044);
    awvalid = 1'b1; awid = 4'd10; awaddr = 16'h0044; awlen = 0; awsize = 3'd2; awburst = 2'd1;
    check_eq("rw_awready", awready, 1);
    tick();
    awvalid = 1'b0;
    wvalid = 1'b1; wdata = ~old_w; wstrb = 4'hF; wlast = 1'b1;
    arvalid = 1'b1; arid = 4'd11; araddr = 16'h0044; arlen = 0; arsize = 3'd2; arburst = 2'd1;
    tick();
    wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
    check_eq("rw_rvalid", rvalid, 1);
    check_eq("rw_old_data", rdata, old_w);
    check_eq("rw_bvalid", bvalid, 1);
    rready = 1'b1; bready = 1'b1;
    tick();
    rready = 1'b0; bready = 1'b0;
    {mem_m[16'h47], mem_m[16'h46], mem_m[16'h45], mem_m[16'h44]} = ~old_w;
    do_read(4'd12, 16'h0044, 8'd0, 3'd2, 2'd1, -1);

    // Reset in the middle of an 8-beat write.
    awvalid = 1'b1; awid = 4'd13; awaddr = 16'h0080; awlen = 8'd7; awsize = 3'd2; awburst = 2'd1;
    tick();
    awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wvalid = 1'b1; wdata = $urandom; wstrb = 4'hF; wlast = 1'b0;
      tick();
      {mem_m[16'h83 + 4*i], mem_m[16'h82 + 4*i], mem_m[16'h81 + 4*i], mem_m[16'h80 + 4*i]} = wdata;
    end
    wvalid = 1'b0;
    areset = 1'b1;
    tick();
    check_eq("mid_rst_wready", wready, 0);
    check_eq("mid_rst_bvalid", bvalid, 0);
    check_eq("mid_rst_rvalid", rvalid, 0);
    areset = 1'b0;
    tick();
    check_eq("post_rst_bvalid", bvalid, 0);
    check_eq("post_rst_awready", awready, 1);
    check_eq("post_rst_wready", wready, 0);
    do_read(4'd14, 16'h0080, 8'd1, 3'd2, 2'd1, -1);

    // Random bursts: write then read back with the same parameters.
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      burst = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      r = $urandom_range(0, 7);
      size = (r == 7) ? 3'd3 : 3'(r % 3);
      if (burst == 2'd2 && $urandom_range(0, 3) != 0) len = 8'((2 << $urandom_range(0, 3)) - 1);
      else len = 8'($urandom_range(0, 7));
      for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
      awaddr = 16'($urandom_range(0, 16'h1080));
      do_write(4'($urandom), awaddr, len, size, burst, $urandom_range(0, 2), $urandom_range(0, 9) == 0);
      do_read(4'($urandom), awaddr, len, size, burst, $urandom_range(0, 8));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
